// File: rtl/sbox_sequencer_if.sv
// Handshake and shared S-box lookup port bundle for sbox_sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface sbox_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        flush;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_in;
    logic [3:0]  sbox_out;

    modport slave (
        input  in_valid, in_data, out_ready, flush, sbox_out,
        output in_ready, out_valid, out_data, sbox_sel, sbox_in
    );

    modport master (
        output in_valid, in_data, out_ready, flush, sbox_out,
        input  in_ready, out_valid, out_data, sbox_sel, sbox_in
    );
endinterface

// File: rtl/sbox_sequencer.sv
// Time-multiplexed DES S-layer: walks the eight 6-bit chunks of a 48-bit word
// through one externally muxed S-box port (S1..S8, one per clock) and returns
// the assembled 32-bit result over a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a word; in_ready high
// RUN   | presenting chunk idx to S-box idx, capturing its nibble each edge
// DONE  | result complete; out_valid high, held until out_ready
module sbox_sequencer (
    input  logic               clk,
    input  logic               rst,
    sbox_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  idx_q;
    logic [47:0] inreg_q;
    logic [31:0] result_q;
    logic [5:0]  chunk;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) state_d = RUN;
            RUN:  if (idx_q == 3'd7) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    // Datapath: input latch on accept, nibble capture and index advance in RUN.
    // Input and result registers survive a flush; only the index is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= 3'd0;
            inreg_q  <= 48'd0;
            result_q <= 32'd0;
        end else if (bus.flush) begin
            idx_q <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        inreg_q <= bus.in_data;
                        idx_q   <= 3'd0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < 8; i++) begin
                        if (idx_q == 3'(i)) begin
                            result_q[31-4*i -: 4] <= bus.sbox_out;
                        end
                    end
                    idx_q <= idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Chunk mux: S1 takes the most significant six bits.
    always_comb begin
        chunk = 6'd0;
        for (int i = 0; i < 8; i++) begin
            if (idx_q == 3'(i)) begin
                chunk = inreg_q[47-6*i -: 6];
            end
        end
    end

    // All outputs are decodes of registered state; the lookup port is parked at zero outside RUN.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = result_q;
    assign bus.sbox_sel  = (state_q == RUN) ? idx_q : 3'd0;
    assign bus.sbox_in   = (state_q == RUN) ? chunk : 6'd0;
endmodule

// File: tb/tb_sbox_sequencer.sv
// Scoreboard bench for sbox_sequencer: a driver pushes the expected S-layer
// result when a word is accepted; a monitor pops and compares on out_valid.
module tb_sbox_sequencer;
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    typedef struct {
        logic [47:0] din;
        logic [31:0] res;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          errors;
    int          checks;
    int          last_acc;
    logic [31:0] last_out;
    exp_t        sb_q[$];

    sbox_sequencer_if bus();

    sbox_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DES S-box: outer bits pick the row, inner four bits the column.
    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] c);
        int v;
        int row;
        int col;
        v   = int'(c);
        row = (v / 32) * 2 + (v % 2);
        col = (v / 2) % 16;
        return 4'(SBOX[box][row*16 + col]);
    endfunction

    function automatic logic [5:0] chunk_of(input logic [47:0] x, input int j);
        return 6'((x >> (42 - 6*j)) & 48'h3F);
    endfunction

    function automatic logic [31:0] des_s_layer(input logic [47:0] x);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 8; i++) begin
            r = r | (32'(sbox_lookup(i, chunk_of(x, i))) << (28 - 4*i));
        end
        return r;
    endfunction

    // Eight S-box instances behind the sbox_sel mux.
    always_comb bus.sbox_out = sbox_lookup(int'(bus.sbox_sel), bus.sbox_in);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Present a word at a negedge and hold it until accepted; returns one negedge after the accept edge.
    task automatic send(input logic [47:0] d);
        exp_t e;
        bit   done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 200 && !done; t++) begin
            if (bus.in_ready && !bus.flush && !rst) begin
                e.din = d;
                e.res = des_s_layer(d);
                e.acc = cyc;
                sb_q.push_back(e);
                last_acc = cyc;
                done = 1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin
        logic        prev_v;
        logic [31:0] held;
        int          d;
        prev_v = 1'b0;
        held   = 32'd0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_v = 1'b0;
                continue;
            end
            if (sb_q.size() > 0 && (cyc - sb_q[0].acc) >= 1 && (cyc - sb_q[0].acc) <= 8) begin
                d = cyc - sb_q[0].acc - 1;
                chk("sbox_sel_run", 64'(bus.sbox_sel), 64'(d));
                chk("sbox_in_run", 64'(bus.sbox_in), 64'(chunk_of(sb_q[0].din, d)));
            end else begin
                chk("sbox_sel_park", 64'(bus.sbox_sel), 64'd0);
                chk("sbox_in_park", 64'(bus.sbox_in), 64'd0);
            end
            if (bus.out_valid) begin
                chk("in_ready_while_valid", 64'(bus.in_ready), 64'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    if (!prev_v) chk("latency", 64'(cyc - sb_q[0].acc), 64'd9);
                    else         chk("out_data_stable", 64'(bus.out_data), 64'(held));
                    held = bus.out_data;
                    if (bus.out_ready && !bus.flush) begin
                        chk("out_data", 64'(bus.out_data), 64'(sb_q[0].res));
                        last_out = bus.out_data;
                        void'(sb_q.pop_front());
                    end
                end
            end
            prev_v = bus.out_valid;
        end
    end

    initial begin
        logic [47:0] a;
        logic [47:0] b;
        int          prev;
        int          t;
        errors        = 0;
        checks        = 0;
        cyc           = 0;
        last_acc      = 0;
        last_out      = 32'd0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 48'd0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_sbox_sel", 64'(bus.sbox_sel), 64'd0);
        chk("rst_sbox_in", 64'(bus.sbox_in), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero and all-ones words against known S-layer values.
        send(48'h000000000000);
        wait_drain();
        chk("all_zero", 64'(last_out), 64'hEFA72C4D);
        send(48'hFFFFFFFFFFFF);
        wait_drain();
        chk("all_ones", 64'(last_out), 64'hD9CE3DCB);

        // Asynchronous reset three captures into a run.
        send({16'($urandom), 32'($urandom)});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun_rst_sbox_sel", 64'(bus.sbox_sel), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Flush while idx is 4, then confirm the block still works.
        send({16'($urandom), 32'($urandom)});
        repeat (4) @(negedge clk);
        chk("flush_point_sel", 64'(bus.sbox_sel), 64'd4);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (12) @(negedge clk);
        send(48'h000000000000);
        wait_drain();
        chk("post_flush_zero", 64'(last_out), 64'hEFA72C4D);

        // Backpressure with a second word waiting.
        a = {16'($urandom), 32'($urandom)};
        b = {16'($urandom), 32'($urandom)};
        bus.out_ready = 1'b0;
        send(a);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
        chk("bp_first_result", 64'(last_out), 64'(des_s_layer(a)));
        send(b);
        bus.out_ready = 1'b1;
        wait_drain();
        chk("bp_second_result", 64'(last_out), 64'(des_s_layer(b)));

        // Back-to-back random words with out_ready held high.
        prev = 0;
        for (int i = 0; i < 200; i++) begin
            send({16'($urandom), 32'($urandom)});
            if (i > 0) chk("accept_spacing", 64'(last_acc - prev), 64'd10);
            prev = last_acc;
        end
        wait_drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
